// File: rtl/spi_apb_arbiter.sv
// Two-requester APB arbiter (m0 = ifetch, m1 = load/store) for the SPI master port; round-robin, or strict m0 priority when SPI_ARB_FIXED_PRIO_EN is defined.
// Latency: request -> out_psel +1 cycle, out_penable +2, requester pready at earliest +2 (one added wait state).
// Backpressure: the loser is held in wait states until the granted transfer completes; out_psel drops for one cycle between transfers.
module spi_apb_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   m0_paddr,
    input  logic                m0_psel,
    input  logic                m0_penable,
    input  logic                m0_pwrite,
    input  logic [DATA_W-1:0]   m0_pwdata,
    input  logic [DATA_W/8-1:0] m0_pstrb,
    input  logic [2:0]          m0_pprot,
    output logic                m0_pready,
    output logic [DATA_W-1:0]   m0_prdata,
    output logic                m0_pslverr,
    input  logic [ADDR_W-1:0]   m1_paddr,
    input  logic                m1_psel,
    input  logic                m1_penable,
    input  logic                m1_pwrite,
    input  logic [DATA_W-1:0]   m1_pwdata,
    input  logic [DATA_W/8-1:0] m1_pstrb,
    input  logic [2:0]          m1_pprot,
    output logic                m1_pready,
    output logic [DATA_W-1:0]   m1_prdata,
    output logic                m1_pslverr,
    output logic [ADDR_W-1:0]   out_paddr,
    output logic                out_pwrite,
    output logic [DATA_W-1:0]   out_pwdata,
    output logic [DATA_W/8-1:0] out_pstrb,
    output logic [2:0]          out_pprot,
    output logic                out_psel,
    output logic                out_penable,
    input  logic                out_pready,
    input  logic [DATA_W-1:0]   out_prdata,
    input  logic                out_pslverr
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t state_q, state_d;
    logic   grant_q;
    logic   last_q;
    logic   win;
    logic   req_any;
    logic   done;

    // Requester penable carries no information for arbitration.
    logic unused_penable;
    assign unused_penable = m0_penable ^ m1_penable;

    assign req_any = m0_psel | m1_psel;
    assign done    = (state_q == ACCESS) && out_pready;

    always_comb begin
        win = m1_psel && !m0_psel;
        if (m0_psel && m1_psel) begin
`ifdef SPI_ARB_FIXED_PRIO_EN
            win = 1'b0;
`else
            win = ~last_q;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_any) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (out_pready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= 1'b0;
            last_q     <= 1'b1;
            out_paddr  <= '0;
            out_pwrite <= 1'b0;
            out_pwdata <= '0;
            out_pstrb  <= '0;
            out_pprot  <= '0;
        end else begin
            state_q <= state_d;
            // Downstream fields are captured once per grant so upstream changes cannot leak mid-transfer.
            if (state_q == IDLE && req_any) begin
                grant_q    <= win;
                out_paddr  <= win ? m1_paddr  : m0_paddr;
                out_pwrite <= win ? m1_pwrite : m0_pwrite;
                out_pwdata <= win ? m1_pwdata : m0_pwdata;
                out_pstrb  <= win ? m1_pstrb  : m0_pstrb;
                out_pprot  <= win ? m1_pprot  : m0_pprot;
            end
            if (done) last_q <= grant_q;
        end
    end

    assign out_psel    = (state_q != IDLE);
    assign out_penable = (state_q == ACCESS);

    assign m0_pready  = done && !grant_q;
    assign m1_pready  = done && grant_q;
    assign m0_prdata  = m0_pready ? out_prdata : '0;
    assign m1_prdata  = m1_pready ? out_prdata : '0;
    assign m0_pslverr = m0_pready && out_pslverr;
    assign m1_pslverr = m1_pready && out_pslverr;

endmodule
